// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, ALU decoder
// interface codes, FSM states and the control-vector layout.
package mips_ctrl_pkg;

  localparam int OPW  = 6;
  localparam int AOPW = 3;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPW-1:0] OP_DADDI = 6'b011000;

  localparam logic [AOPW-1:0] ALU_ADD   = 3'b000;
  localparam logic [AOPW-1:0] ALU_SUB   = 3'b001;
  localparam logic [AOPW-1:0] ALU_RTYPE = 3'b010;
  localparam logic [AOPW-1:0] ALU_AND   = 3'b011;
  localparam logic [AOPW-1:0] ALU_OR    = 3'b100;
  localparam logic [AOPW-1:0] ALU_SLT   = 3'b101;
  localparam logic [AOPW-1:0] ALU_DADD  = 3'b110;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
    S_RTYPEWB, S_BEQEX, S_BNEEX, S_IMMEX, S_IMMWB, S_JEX
  } state_t;

  typedef struct packed {
    logic            pcwrite;
    logic            branch;
    logic            branchne;
    logic            iord;
    logic            memwrite;
    logic            irwrite;
    logic            regdst;
    logic            memtoreg;
    logic            regwrite;
    logic            alusrca;
    logic [1:0]      alusrcb;
    logic            zeroext;
    logic [1:0]      pcsrc;
    logic [AOPW-1:0] aluop;
    logic            illegal_op;
  } ctrl_t;

  function automatic logic is_supported(input logic [OPW-1:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_DADDI: is_supported = 1'b1;
      default:                                     is_supported = 1'b0;
    endcase
  endfunction

  function automatic logic [AOPW-1:0] imm_aluop(input logic [OPW-1:0] op);
    case (op)
      OP_ANDI:  imm_aluop = ALU_AND;
      OP_ORI:   imm_aluop = ALU_OR;
      OP_SLTI:  imm_aluop = ALU_SLT;
      OP_DADDI: imm_aluop = ALU_DADD;
      default:  imm_aluop = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/maindec_outdec.sv
// Combinational state-to-control-vector decode for the main controller.
// FETCH strobes are emitted raw; the FSM gates them with memready.
module maindec_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t         state,
  input  logic [OPW-1:0] op,
  output ctrl_t          ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALU_ADD;
        ctrl.pcsrc   = PC_ALU;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb    = SRCB_IMMSH;
        ctrl.aluop      = ALU_ADD;
        ctrl.illegal_op = ~is_supported(op);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_RTYPE;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.alusrcb  = SRCB_B;
        ctrl.aluop    = ALU_SUB;
        ctrl.pcsrc    = PC_ALUOUT;
        ctrl.branch   = (state == S_BEQEX);
        ctrl.branchne = (state == S_BNEEX);
      end
      S_IMMEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = imm_aluop(op);
        ctrl.zeroext = (op == OP_ANDI) || (op == OP_ORI);
      end
      S_IMMWB: ctrl.regwrite = 1'b1;
      S_JEX: begin
        ctrl.pcsrc   = PC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/maindec_fsm.sv
// Multicycle MIPS main controller: state register, opcode-driven sequencing,
// memready handshake and reset masking of the write/strobe outputs.
module maindec_fsm
  import mips_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  op,
  input  logic            memready,
  output logic            pcwrite,
  output logic            branch,
  output logic            branchne,
  output logic            iord,
  output logic            memwrite,
  output logic            irwrite,
  output logic            regdst,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic            zeroext,
  output logic [1:0]      pcsrc,
  output logic [AOPW-1:0] aluop,
  output logic            illegal_op
);

  state_t state;
  state_t dec_state;
  ctrl_t  ctrl;
  logic   gate;
  logic   run;

  // During reset the datapath already sees FETCH selects, but no strobe fires.
  assign dec_state = reset ? S_FETCH : state;
  assign run       = ~reset;
  assign gate      = (dec_state == S_FETCH) ? memready : 1'b1;

  maindec_outdec u_outdec (
    .state (dec_state),
    .op    (op),
    .ctrl  (ctrl)
  );

  assign pcwrite    = run & gate & ctrl.pcwrite;
  assign irwrite    = run & gate & ctrl.irwrite;
  assign branch     = run & ctrl.branch;
  assign branchne   = run & ctrl.branchne;
  assign memwrite   = run & ctrl.memwrite;
  assign regwrite   = run & ctrl.regwrite;
  assign illegal_op = run & ctrl.illegal_op;
  assign iord       = ctrl.iord;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign zeroext    = ctrl.zeroext;
  assign pcsrc      = ctrl.pcsrc;
  assign aluop      = ctrl.aluop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:   state <= memready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_RTYPEEX;
            OP_BEQ:       state <= S_BEQEX;
            OP_BNE:       state <= S_BNEEX;
            OP_J:         state <= S_JEX;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_DADDI: state <= S_IMMEX;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:  state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   state <= memready ? S_MEMWB : S_MEMRD;
        S_MEMWB:   state <= S_FETCH;
        S_MEMWR:   state <= memready ? S_FETCH : S_MEMWR;
        S_RTYPEEX: state <= S_RTYPEWB;
        S_RTYPEWB: state <= S_FETCH;
        S_BEQEX:   state <= S_FETCH;
        S_BNEEX:   state <= S_FETCH;
        S_IMMEX:   state <= S_IMMWB;
        S_IMMWB:   state <= S_FETCH;
        S_JEX:     state <= S_FETCH;
        default:   state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_maindec_fsm.sv
// Self-checking bench for maindec_fsm: directed instruction scenarios, then
// random instruction/memready/reset traffic against an instruction-step model.
module tb_maindec_fsm;

  logic       clk, reset, memready;
  logic [5:0] op;
  logic       pcwrite, branch, branchne, iord, memwrite, irwrite, regdst;
  logic       memtoreg, regwrite, alusrca, zeroext, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;

  int checks = 0;
  int errors = 0;
  int step   = 0;
  int n_rw, n_iord, n_mw, n_ill, n_cyc;

  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_BNE = 4;
  localparam int C_J = 5, C_IMM = 6, C_ILL = 7;

  maindec_fsm dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .pcwrite(pcwrite), .branch(branch), .branchne(branchne), .iord(iord),
    .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc), .aluop(aluop),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int classify(input logic [5:0] o);
    case (o)
      6'b000000: return C_R;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000101: return C_BNE;
      6'b000010: return C_J;
      6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b011000: return C_IMM;
      default:   return C_ILL;
    endcase
  endfunction

  // Index of the final step of each instruction class (step 0 is the fetch).
  function automatic int last_step(input int c);
    case (c)
      C_LW:                return 4;
      C_R, C_SW, C_IMM:    return 3;
      C_BEQ, C_BNE, C_J:   return 2;
      default:             return 1;
    endcase
  endfunction

  function automatic logic [18:0] mk(input logic pcw, br, brn, io, mw, irw,
      rd, mtr, rw, asa, input logic [1:0] asb, input logic ze,
      input logic [1:0] pcs, input logic [2:0] aop, input logic ill);
    return {pcw, br, brn, io, mw, irw, rd, mtr, rw, asa, asb, ze, pcs, aop, ill};
  endfunction

  function automatic logic [18:0] exp_vec(input int st, input logic [5:0] o,
                                          input logic mr);
    int         c;
    logic [2:0] iaop;
    logic       ze;
    c    = classify(o);
    ze   = (o == 6'b001100) || (o == 6'b001101);
    case (o)
      6'b001100: iaop = 3'b011;
      6'b001101: iaop = 3'b100;
      6'b001010: iaop = 3'b101;
      6'b011000: iaop = 3'b110;
      default:   iaop = 3'b000;
    endcase
    if (st == 0)
      return mk(mr,1'b0,1'b0,1'b0,1'b0,mr,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,3'b000,1'b0);
    if (st == 1)
      return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,2'b00,3'b000,
                c == C_ILL);
    if (st == 2) begin
      case (c)
        C_LW, C_SW: return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,3'b000,1'b0);
        C_R:   return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,3'b010,1'b0);
        C_BEQ: return mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,3'b001,1'b0);
        C_BNE: return mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,3'b001,1'b0);
        C_J:   return mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b10,3'b000,1'b0);
        C_IMM: return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,ze,2'b00,iaop,1'b0);
        default: return 19'h7ffff;
      endcase
    end
    if (st == 3) begin
      case (c)
        C_LW:  return mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0);
        C_SW:  return mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0);
        C_R:   return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0);
        C_IMM: return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0);
        default: return 19'h7ffff;
      endcase
    end
    return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0);
  endfunction

  function automatic int next_step(input int st, input logic [5:0] o, input logic mr);
    int c;
    logic waits;
    c     = classify(o);
    waits = (st == 0) || (st == 3 && (c == C_LW || c == C_SW));
    if (waits && !mr) return st;
    if (st == last_step(c)) return 0;
    return st + 1;
  endfunction

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, compare all outputs mid-cycle, advance the model.
  task automatic cyc(input logic mr, input logic rst);
    logic [18:0] got, expv;
    memready = mr;
    reset    = rst;
    @(negedge clk);
    got = {pcwrite, branch, branchne, iord, memwrite, irwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, zeroext, pcsrc, aluop, illegal_op};
    if (rst)
      expv = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,3'b000,1'b0);
    else
      expv = exp_vec(step, op, mr);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL outputs step=%0d op=%b rst=%b mr=%b got=%b exp=%b",
             step, op, rst, mr, got, expv);
    end
    n_rw   += int'(regwrite);
    n_iord += int'(iord);
    n_mw   += int'(memwrite);
    n_ill  += int'(illegal_op);
    n_cyc++;
    step = rst ? 0 : next_step(step, op, mr);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_rw = 0; n_iord = 0; n_mw = 0; n_ill = 0; n_cyc = 0;
  endtask

  initial begin
    logic [5:0] legal [11];
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
              6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b011000};
    op = 6'b000000; memready = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);

    // R-type: four cycles, single regwrite pulse
    clr(); op = 6'b000000;
    repeat (4) cyc(1'b1, 1'b0);
    check_int("rtype_regwrite", n_rw, 1);
    check_int("rtype_back_fetch", step, 0);

    // LW with two stalled memory-read cycles
    clr(); op = 6'b100011;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    check_int("lw_iord_cycles", n_iord, 3);
    check_int("lw_regwrite", n_rw, 1);
    check_int("lw_back_fetch", step, 0);

    // SW with one stalled write cycle
    clr(); op = 6'b101011;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0); cyc(1'b1, 1'b0);
    check_int("sw_memwrite_cycles", n_mw, 2);
    check_int("sw_no_regwrite", n_rw, 0);

    // ANDI, DADDI, BNE, J
    op = 6'b001100; repeat (4) cyc(1'b1, 1'b0);
    op = 6'b011000; repeat (4) cyc(1'b1, 1'b0);
    op = 6'b000101; repeat (3) cyc(1'b1, 1'b0);
    op = 6'b000010; repeat (3) cyc(1'b1, 1'b0);
    check_int("j_back_fetch", step, 0);

    // Illegal opcode
    clr(); op = 6'b111111;
    repeat (2) cyc(1'b1, 1'b0);
    check_int("illegal_pulse", n_ill, 1);
    check_int("illegal_back_fetch", step, 0);

    // Reset while a store waits in the write state
    clr(); op = 6'b101011;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    check_int("reset_memwrite_count", n_mw, 1);

    // Random instruction traffic
    for (int i = 0; i < 3000; i++) begin
      if (step == 0) begin
        if ($urandom_range(0, 7) == 0) op = 6'($urandom);
        else op = legal[$urandom_range(0, 10)];
      end
      cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
          ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maindec_fsm.md
Name: maindec_fsm

Overview:
- Multicycle MIPS main controller, directly upstream of the ALU decoder.
- Decodes the 6-bit opcode and steps the datapath through fetch, decode, execute, memory and writeback.
- Drives all datapath enables and mux selects, plus the 3-bit aluop consumed by the ALU decoder.
- Memory accesses wait on a memready handshake.

Parameters:
- OPW, 6, opcode width.
- AOPW, 3, aluop width (fixed by the ALU decoder interface).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  6  opcode field of the instruction register.
- memready  input  1  memory has completed the current read or write this cycle.
- pcwrite  output  1  unconditional PC load.
- branch  output  1  PC load if ALU zero flag = 1 (BEQ).
- branchne  output  1  PC load if ALU zero flag = 0 (BNE).
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  output  1  memory write strobe.
- irwrite  output  1  instruction register load.
- regdst  output  1  destination register: 1 = rd, 0 = rt.
- memtoreg  output  1  writeback data: 1 = data register, 0 = ALUOut.
- regwrite  output  1  register file write.
- alusrca  output  1  ALU A input: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B input: 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- zeroext  output  1  immediate zero-extended instead of sign-extended (ANDI/ORI).
- pcsrc  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  output  3  to ALU decoder: 000 add, 001 sub, 010 R-type, 011 and, 100 or, 101 slt, 110 dadd.
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is synchronous and active-high, named reset. reset=1 at a rising edge sets state to FETCH.
- While reset=1, outputs are forced low: pcwrite, branch, branchne, memwrite, irwrite, regwrite, illegal_op. Other outputs show FETCH values.
- All outputs are Moore (a function of state only), except pcwrite and irwrite in FETCH, which are ANDed with memready.
- Unlisted outputs are 0 in every state.
- Supported opcodes:
  - RTYPE 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010
  - ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, DADDI 011000
- States and transitions:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00, irwrite=pcwrite=memready. Hold while memready=0; go to DECODE when memready=1.
  - DECODE: alusrca=0, alusrcb=11, aluop=000. Next state by op:
    - LW/SW -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; BNE -> BNEEX; J -> JEX
    - ADDI/ANDI/ORI/SLTI/DADDI -> IMMEX
    - any other op -> FETCH, with illegal_op=1 for this cycle.
  - MEMADR: alusrca=1, alusrcb=10, aluop=000. LW -> MEMRD; SW -> MEMWR.
  - MEMRD: iord=1. Hold until memready=1, then -> MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. -> FETCH.
  - MEMWR: iord=1, memwrite=1. Hold (memwrite stays high) until memready=1, then -> FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=010. -> RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1. -> FETCH.
  - BEQEX / BNEEX: alusrca=1, alusrcb=00, aluop=001, pcsrc=01, branch=1 (BEQEX) or branchne=1 (BNEEX). -> FETCH.
  - IMMEX: alusrca=1, alusrcb=10. aluop: ADDI 000, ANDI 011, ORI 100, SLTI 101, DADDI 110. zeroext=1 for ANDI/ORI only. -> IMMWB.
  - IMMWB: regdst=0, memtoreg=0, regwrite=1. -> FETCH.
  - JEX: pcsrc=10, pcwrite=1. -> FETCH.
- Opcode latching: op is sampled only in DECODE, MEMADR and IMMEX; the IR is stable from FETCH exit until the next FETCH.
- Latency with memready always 1:
  - R-type 4 cycles, immediate 4, LW 5, SW 4, BEQ/BNE 3, J 3.
  - Each memready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- Reset mid-instruction: any state returns to FETCH on the next edge; no partial writes complete after reset is sampled.
- State encoding is unconstrained; any unreachable encoding returns to FETCH.

Decomposition:
- Shared package mips_ctrl_pkg:
  - opcode localparams
  - aluop localparams (shared with the ALU decoder)
  - state enum typedef
  - alusrcb and pcsrc encodings
- Sub-module maindec_outdec: pure combinational state-to-control-vector decode. The FSM keeps state register, next-state logic and memready gating.

Test Plan:
- Reset with memready=1, then IR op=000000: states FETCH, DECODE, RTYPEEX (aluop=010), RTYPEWB (regwrite=1, regdst=1), FETCH; exactly one regwrite pulse in 4 cycles.
- op=100011 with memready low for 2 cycles in MEMRD: iord=1 held 3 cycles, then MEMWB with memtoreg=1, regwrite=1; total 7 cycles.
- op=101011 with memready=0 one cycle in MEMWR: memwrite=1 for 2 consecutive cycles, regwrite never asserts.
- op=001100 (ANDI): IMMEX gives aluop=011, zeroext=1, alusrcb=10. op=011000 (DADDI): aluop=110, zeroext=0.
- op=000101 (BNE): BNEEX gives branchne=1, branch=0, aluop=001, pcsrc=01. op=000010 (J): pcwrite=1, pcsrc=10; 3 cycles each.
- op=111111: illegal_op pulses 1 cycle in DECODE, then FETCH. reset asserted in MEMWR with memready=0: next cycle state FETCH, and memwrite=0 while reset=1.
